// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for multiplier-sharing arbiters.
// Operand type, default sizing and the round-robin picker.
package mult_arb_pkg;

  localparam int MULT_W       = 64;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MULT_LAT = 8;

  typedef logic [MULT_W-1:0] operand_t;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
    logic [7:0] onehot;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo n (n <= 8).
  function automatic pick_t rr_pick(
    input logic [7:0] valid,
    input logic [2:0] ptr,
    input int         n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !p.any && valid[j[2:0]]) begin
        p.any            = 1'b1;
        p.idx            = j[2:0];
        p.onehot[j[2:0]] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mult_tag_fifo.sv
// Small synchronous tag FIFO for shared-unit arbiters.
// Same-cycle push and pop are allowed, including when full.
module mult_tag_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined multiplier.
// Tags each issue and routes each result back to its owner.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ  = DEF_NUM_REQ,
  parameter  int MULT_LAT = DEF_MULT_LAT,
  parameter  int ID_W     = $clog2(NUM_REQ),
  localparam int CW       = $clog2(MULT_LAT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*64-1:0]  req_mcand,
  input  logic [NUM_REQ*64-1:0]  req_mplier,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   hold,
  output logic                   mult_start,
  output operand_t               mult_mcand,
  output operand_t               mult_mplier,
  input  operand_t               mult_product,
  input  logic                   mult_done,
  output logic [NUM_REQ-1:0]     resp_valid,
  output operand_t               resp_product,
  output logic                   busy,
  output logic                   err_orphan
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] tag_head;
  logic [CW-1:0]   inflight;
  logic            full;
  logic            empty;
  logic            take;
  logic            pop_ok;
  pick_t           pick;
  logic            pick_unused;

  assign pick_unused = &{1'b0, pick};
  assign gnt_id      = ID_W'(pick.idx);
  assign pop_ok      = mult_done && !empty;
  assign busy        = (inflight != '0);

  // Combinational grant; suppressed in reset, on hold and when full.
  always_comb begin
    pick      = rr_pick(8'(req_valid), 3'(rr_ptr), NUM_REQ);
    req_ready = '0;
    take      = 1'b0;
    if (reset && !hold && !full && pick.any) begin
      req_ready = NUM_REQ'(1) << gnt_id;
      take      = 1'b1;
    end
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_start  <= 1'b0;
      mult_mcand  <= '0;
      mult_mplier <= '0;
      rr_ptr      <= '0;
    end else begin
      mult_start <= take;
      if (take) begin
        mult_mcand  <= req_mcand[int'(gnt_id)*MULT_W +: MULT_W];
        mult_mplier <= req_mplier[int'(gnt_id)*MULT_W +: MULT_W];
        rr_ptr      <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0
                                                      : gnt_id + 1'b1;
      end
    end
  end

  // Response register and sticky orphan flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid   <= '0;
      resp_product <= '0;
      err_orphan   <= 1'b0;
    end else begin
      resp_valid <= pop_ok ? (NUM_REQ'(1) << tag_head) : '0;
      if (pop_ok) resp_product <= mult_product;
      if (mult_done && empty) err_orphan <= 1'b1;
    end
  end

  mult_tag_fifo #(
    .DEPTH (MULT_LAT),
    .WIDTH (ID_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (take),
    .din   (gnt_id),
    .pop   (mult_done),
    .dout  (tag_head),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter.
// A behavioural 8-stage multiplier stands in for mult.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            hold  = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*64-1:0] req_mcand;
  logic [N*64-1:0] req_mplier;
  logic [N-1:0]    req_ready;
  logic            mult_start;
  logic [63:0]     mult_mcand;
  logic [63:0]     mult_mplier;
  logic [63:0]     mult_product;
  logic            mult_done;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_product;
  logic            busy;
  logic            err_orphan;

  logic            stub_block  = 1'b0;
  logic            man_done    = 1'b0;
  logic [63:0]     man_product = '0;
  logic [7:0]      pipe_v;
  logic [63:0]     pipe_p [8];

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0]  gexp [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [63:0] pexp [8] = '{64'd1, 64'd4, 64'd9, 64'd16,
                            64'd5, 64'd12, 64'd21, 64'd32};

  always #5 clock = ~clock;

  mult_share_arbiter #(
    .NUM_REQ  (N),
    .MULT_LAT (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .req_ready    (req_ready),
    .hold         (hold),
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_product (mult_product),
    .mult_done    (mult_done),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .busy         (busy),
    .err_orphan   (err_orphan)
  );

  // Multiplier stand-in: valid pipe with async reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pipe_v <= '0;
    else        pipe_v <= {pipe_v[6:0], mult_start};
  end

  // Multiplier stand-in: product pipe.
  always_ff @(posedge clock) begin
    pipe_p[0] <= mult_mcand * mult_mplier;
    for (int k = 1; k < 8; k++) pipe_p[k] <= pipe_p[k-1];
  end

  assign mult_done    = (pipe_v[7] & ~stub_block) | man_done;
  assign mult_product = man_done ? man_product : pipe_p[7];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a,
                        input logic [63:0] b);
    req_mcand[64*i +: 64]  = a;
    req_mplier[64*i +: 64] = b;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = '0;
    hold       = 1'b0;
    stub_block = 1'b0;
    man_done   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    req_valid  = '0;
    req_mcand  = '0;
    req_mplier = '0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", mult_start, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_orphan", err_orphan, 0);
    do_reset();

    // single op
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_start", mult_start, 1);
    chk("t1_mcand", mult_mcand, 3);
    chk("t1_mplier", mult_mplier, 5);
    chk("t1_busy1", busy, 1);
    tick();
    chk("t1_start_off", mult_start, 0);
    repeat (7) tick();
    chk("t1_resp_early", resp_valid, 0);
    chk("t1_busy9", busy, 1);
    tick();
    chk("t1_resp", resp_valid, 4'b0001);
    chk("t1_prod", resp_product, 15);
    chk("t1_idle", busy, 0);

    // all four requesters, back to back
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) set_op(i, 64'(i + 1), 64'(k + 1));
      req_valid = 4'hF;
      #1;
      chk($sformatf("t2_grant%0d", k), req_ready, gexp[k]);
      tick();
    end
    req_valid = '0;
    tick();
    chk("t2_resp_early", resp_valid, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t2_resp%0d", k), resp_valid, gexp[k]);
      chk($sformatf("t2_prod%0d", k), resp_product, pexp[k]);
    end
    chk("t2_idle", busy, 0);

    // fairness
    do_reset();
    set_op(0, 1, 1);
    set_op(2, 2, 2);
    req_valid = 4'b0001;
    #1;
    chk("t3_ready0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0101;
    #1;
    chk("t3_ready2", req_ready, 4'b0100);
    tick();
    chk("t3_ptr3", dut.rr_ptr, 3);
    req_valid = 4'b0001;
    #1;
    chk("t3_ready0b", req_ready, 4'b0001);
    tick();
    chk("t3_ptr1", dut.rr_ptr, 1);
    req_valid = '0;

    // full guard
    do_reset();
    stub_block = 1'b1;
    set_op(0, 2, 3);
    req_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t4_issue%0d", k), req_ready, 4'b0001);
      tick();
    end
    #1;
    chk("t4_full", req_ready, 0);
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_full2", req_ready, 0);
    man_product = 64'h77;
    man_done    = 1'b1;
    #1;
    chk("t4_full3", req_ready, 0);
    tick();
    man_done = 1'b0;
    #1;
    chk("t4_resp", resp_valid, 4'b0001);
    chk("t4_prod", resp_product, 64'h77);
    chk("t4_reopen", req_ready, 4'b0001);
    tick();
    chk("t4_refull", req_ready, 0);
    req_valid = '0;

    // hold
    do_reset();
    set_op(0, 6, 7);
    req_valid = 4'b0001;
    #1;
    chk("t5_ready", req_ready, 4'b0001);
    tick();
    hold = 1'b1;
    set_op(1, 9, 10);
    set_op(2, 4, 4);
    req_valid = 4'b0110;
    #1;
    chk("t5_start_pre", mult_start, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d", i), req_ready, 0);
      tick();
      chk($sformatf("t5_nostart%0d", i), mult_start, 0);
    end
    chk("t5_ptr", dut.rr_ptr, 1);
    hold = 1'b0;
    #1;
    chk("t5_resume", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("t5_start", mult_start, 1);
    chk("t5_mcand", mult_mcand, 9);
    repeat (3) tick();
    chk("t5_resp0", resp_valid, 4'b0001);
    chk("t5_prod0", resp_product, 42);
    repeat (6) tick();
    chk("t5_resp1", resp_valid, 4'b0010);
    chk("t5_prod1", resp_product, 90);

    // reset mid-operation, orphan, wide product
    do_reset();
    set_op(0, 1, 2);
    set_op(1, 3, 4);
    set_op(2, 5, 6);
    req_valid = 4'b0111;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("t6_ready", req_ready, 0);
    chk("t6_start", mult_start, 0);
    chk("t6_mcand", mult_mcand, 0);
    chk("t6_mplier", mult_mplier, 0);
    chk("t6_resp", resp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_orphan0", err_orphan, 0);
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    man_product = 64'd5;
    man_done    = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t6_orphan", err_orphan, 1);
    chk("t6_noresp", resp_valid, 0);
    chk("t6_idle", busy, 0);
    tick();
    chk("t6_sticky", err_orphan, 1);
    set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    req_valid = 4'b0001;
    #1;
    chk("t6_ready2", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (9) tick();
    chk("t6_wresp", resp_valid, 4'b0001);
    chk("t6_wprod", resp_product, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one fully pipelined 64x64 multiplier (the 8-stage `mult`; fixed latency, one issue per cycle) among NUM_REQ requesters.
- Arbitrates round-robin on a valid/ready request handshake and drives the multiplier's `start`, `mcand` and `mplier`.
- Records the requester ID of every issued operation in a tag FIFO, then routes each `done` result back to that requester.
- Sits between the requesting units and a `mult` instance, both of which the parent instantiates.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MULT_LAT, 8, multiplier latency in cycles from `start` to `done`; also the tag FIFO depth.
- ID_W, $clog2(NUM_REQ), requester ID width (derived; do not override).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_mcand  in  NUM_REQ*64  packed multiplicands; requester i occupies bits [64*i+63:64*i].
- req_mplier  in  NUM_REQ*64  packed multipliers, same packing as req_mcand.
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i].
- hold  in  1  when 1, no new grants are issued; in-flight operations still complete.
- mult_start  out  1  issue strobe to the multiplier.
- mult_mcand  out  64  operand to the multiplier.
- mult_mplier  out  64  operand to the multiplier.
- mult_product  in  64  result from the multiplier.
- mult_done  in  1  result-valid strobe from the multiplier.
- resp_valid  out  NUM_REQ  one-hot response strobe; no backpressure.
- resp_product  out  64  product belonging to the strobed requester.
- busy  out  1  1 while any operation is in flight.
- err_orphan  out  1  sticky; set when mult_done arrives with an empty tag FIFO.

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs go to 0.
  - RR pointer goes to 0; tag FIFO and in-flight counter are cleared.
  - err_orphan is cleared.
- Arbitration (combinational req_ready, registered issue):
  - The grant goes to the first i with req_valid[i]==1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is all-zero when hold==1, when no request is valid, or when inflight==MULT_LAT.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - At most one bit of req_ready is set per cycle.
- Issue (on a handshake for requester g):
  - Next edge: mult_start=1 with mult_mcand/mult_mplier equal to requester g's operands. That single-cycle pulse is the only point where mult_start is asserted.
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged in cycles with no grant.
  - With no issue, mult_start=0 and the operand registers hold their values.
- Response:
  - On mult_done==1, pop the tag FIFO head h.
  - Next edge: resp_valid = one-hot(h) and resp_product = the registered mult_product.
  - resp_valid is a 1-cycle pulse. resp_product holds its value until the next response.
- Latency:
  - Request handshake to resp_valid is MULT_LAT+2 cycles: 1 issue register + MULT_LAT + 1 response register.
  - Sustained throughput is one operation per cycle.
- Ordering:
  - Results return in issue order, so the FIFO is sufficient; no reorder logic.
- In-flight counter (width $clog2(MULT_LAT+1)):
  - +1 on issue, -1 on mult_done, unchanged when both happen in the same cycle.
  - busy = (inflight != 0).
  - A push and a pop in the same cycle are both legal, including at full and empty.
- Boundaries:
  - Full (inflight==MULT_LAT): no grant, which rules out FIFO overflow. This cannot occur with a correct multiplier, but the guard is required.
  - mult_done with an empty FIFO: set err_orphan, emit no resp_valid, leave FIFO state unchanged.
  - Reset mid-operation: in-flight tags are discarded. The parent must reset the multiplier in the same cycle; otherwise stale dones raise err_orphan.
  - hold rising while a request is pending: that request is not granted; rr_ptr is unchanged.
- State machine: none beyond the FIFO and pointer. The block is a single pipeline with the registers rr_ptr, issue regs, FIFO (wr_ptr, rd_ptr, count) and response regs.

Decomposition:
- Package mult_arb_pkg holds:
  - localparam MULT_W=64
  - default NUM_REQ and MULT_LAT
  - the typedef for the 64-bit operand
  - function rr_pick(valid, ptr) returning a one-hot grant and its index.
- Sub-module mult_tag_fifo:
  - synchronous FIFO, DEPTH=MULT_LAT, WIDTH=ID_W
  - push/pop/full/empty/count
  - same clock and async active-low reset
  - reused by other shared-unit arbiters.

Test Plan:
1. Single op: req_valid=0001, operands 3 and 5 -> req_ready=0001 same cycle; mult_start 1 cycle later; resp_valid=0001 with product 15 at handshake+10; busy high throughout.
2. All four requesters valid for 8 cycles, operands (i+1)*(k+1) -> grants in order 0,1,2,3,0,1,2,3; responses in the same order with correct products; one result per cycle.
3. Fairness: requester 0 valid continuously, requester 2 asserts one request -> requester 2 granted within 2 cycles; rr_ptr becomes 3.
4. Full guard with a stub multiplier that withholds done -> after 8 issues req_ready=0; one stub done reopens exactly one grant.
5. hold=1 for 5 cycles with requests pending -> no grants or starts; previously issued results still return; hold=0 resumes at the same rr_ptr.
6. Reset mid-operation: reset=0 with 3 ops in flight -> all outputs 0 immediately; stray mult_done after release sets err_orphan with no resp_valid; 0xFFFFFFFFFFFFFFFF * 2 -> product 0xFFFFFFFFFFFFFFFE (low 64 bits).
